// File: rtl/up_counter_ctl.sv
`default_nettype none
// ============================================================================
// Module      : up_counter_ctl
// Description : Controllable up-counter with free-run (wrap at MAX, carry out
//               for cascading, sticky overflow) and one-shot (count from 0 to
//               a latched limit, then stop and flag done) modes.
// Revision    : 1.0 - initial release
// ============================================================================
module up_counter_ctl #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic             overflow
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] c_max      = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_zero     = '0;
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

  localparam logic [1:0]       c_st_idle  = 2'd0;
  localparam logic [1:0]       c_st_run   = 2'd1;
  localparam logic [1:0]       c_st_done  = 2'd2;

  // An out-of-range MAX would let values above the wrap point be stored, so
  // refuse to elaborate rather than build a counter that misbehaves.
  generate
    if ((MAX <= 0) || (MAX > ((2 ** WIDTH) - 1))) begin : g_bad_max
      $error("up_counter_ctl: MAX must satisfy 0 < MAX <= 2**WIDTH-1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic             mode_q,     mode_d;     // 1 = one-shot, 0 = free-run
  logic [WIDTH-1:0] limit_q,    limit_d;    // one-shot terminal, already clamped
  logic             overflow_q, overflow_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_limit_clamped;
  logic             w_at_max;

  // Increment and clamp values shared by the next-state logic.
  always_comb begin
    w_count_inc     = count_q + c_one;
    w_load_clamped  = (load_val > c_max) ? c_max : load_val;
    w_limit_clamped = (limit > c_max) ? c_max : limit;
    w_at_max        = (count_q == c_max);
  end

  // State register: all architectural state updates on the rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_st_idle;
      count_q    <= c_zero;
      mode_q     <= 1'b0;
      limit_q    <= c_zero;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      limit_q    <= limit_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic; the if/else chain encodes stop > start > load > count.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mode_d     = mode_q;
    limit_d    = limit_q;
    overflow_d = overflow_q;

    if (stop) begin
      // Abort: park in IDLE with count and overflow preserved for inspection.
      state_d = c_st_idle;
    end else if (start) begin
      // Start (or restart) always wins over a concurrent load or increment.
      state_d    = c_st_run;
      count_d    = c_zero;
      mode_d     = one_shot;
      limit_d    = w_limit_clamped;
      overflow_d = 1'b0;
    end else if (load) begin
      // Load leaves the state alone and takes the place of this cycle's count.
      count_d = w_load_clamped;
    end else if (en && (state_q == c_st_run)) begin
      if (!mode_q) begin
        if (w_at_max) begin
          count_d    = c_zero;
          overflow_d = 1'b1;
        end else begin
          count_d = w_count_inc;
        end
      end else begin
        // A load may have placed count at or beyond the limit; finish there
        // instead of incrementing further.
        if (count_q >= limit_q) begin
          state_d = c_st_done;
        end else begin
          count_d = w_count_inc;
          if (w_count_inc == limit_q) begin
            state_d = c_st_done;
          end
        end
      end
    end
  end

  // Output decode; carry is combinational so a cascaded stage steps on the
  // same edge on which this stage wraps.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    carry_out = 1'b0;
    case (state_q)
      c_st_run: begin
        busy      = 1'b1;
        carry_out = en && !mode_q && w_at_max;
      end
      c_st_done: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_up_counter_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_up_counter_ctl
// Description : Directed self-checking bench for up_counter_ctl (WIDTH=4,
//               MAX=9) including a units/tens decade cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_up_counter_ctl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       start;
  logic       stop;
  logic       one_shot;
  logic [3:0] limit;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       carry_out;
  logic       overflow;

  logic [3:0] t_count;
  logic       t_busy;
  logic       t_done;
  logic       t_carry;
  logic       t_overflow;

  int total;
  int bad;

  up_counter_ctl #(.WIDTH(4), .MAX(9)) u_dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .stop(stop),
    .one_shot(one_shot), .limit(limit), .load(load), .load_val(load_val),
    .count(count), .busy(busy), .done(done), .carry_out(carry_out),
    .overflow(overflow)
  );

  // Tens stage of a decade cascade, clocked by the units carry.
  up_counter_ctl #(.WIDTH(4), .MAX(9)) u_tens (
    .clk(clk), .reset(reset), .en(carry_out), .start(start), .stop(stop),
    .one_shot(one_shot), .limit(limit), .load(1'b0), .load_val(4'd0),
    .count(t_count), .busy(t_busy), .done(t_done), .carry_out(t_carry),
    .overflow(t_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; start = 0; stop = 0; load = 0; load_val = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); one_shot = 0; limit = 0;
    step(); step();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    reset = 0;
  endtask

  task automatic test_free_run();
    one_shot = 0; start = 1; step(); start = 0;
    total++; if (busy !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL fr_start busy=%b count=%0d exp busy=1 count=0", busy, count); end
    en = 1;
    for (int i = 1; i <= 12; i++) begin
      // carry is high exactly while count sits at 9 with en high
      total++; if (carry_out !== (i == 10)) begin bad++; $display("FAIL fr_carry cycle=%0d got=%b exp=%b", i, carry_out, (i == 10)); end
      step();
      total++; if (count !== 4'(i % 10)) begin bad++; $display("FAIL fr_count cycle=%0d got=%0d exp=%0d", i, count, i % 10); end
      total++; if (overflow !== (i >= 10)) begin bad++; $display("FAIL fr_overflow cycle=%0d got=%b exp=%b", i, overflow, (i >= 10)); end
    end
    en = 0; stop = 1; step(); stop = 0;
  endtask

  task automatic test_one_shot();
    one_shot = 1; limit = 4'd5; start = 1; step(); start = 0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL os_ovf_clear got=%b exp=0", overflow); end
    en = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++; if (count !== 4'(i)) begin bad++; $display("FAIL os_count cycle=%0d got=%0d exp=%0d", i, count, i); end
      total++; if (done !== (i == 5) || busy !== (i != 5)) begin bad++; $display("FAIL os_flags cycle=%0d done=%b busy=%b exp done=%b", i, done, busy, (i == 5)); end
      total++; if (carry_out !== 1'b0) begin bad++; $display("FAIL os_carry cycle=%0d got=%b exp=0", i, carry_out); end
    end
    step(); step(); step();
    total++; if (count !== 4'd5 || done !== 1'b1) begin bad++; $display("FAIL os_hold count=%0d done=%b exp count=5 done=1", count, done); end
    start = 1; step(); start = 0; en = 0;
    total++; if (count !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL os_restart count=%0d busy=%b done=%b exp 0/1/0", count, busy, done); end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_limit_clamp();
    one_shot = 1; limit = 4'd12; start = 1; step(); start = 0; en = 1;
    for (int i = 1; i <= 9; i++) begin
      step();
      total++; if (count !== 4'(i) || done !== (i == 9)) begin bad++; $display("FAIL clamp cycle=%0d count=%0d done=%b exp count=%0d done=%b", i, count, done, i, (i == 9)); end
    end
    step();
    total++; if (count !== 4'd9) begin bad++; $display("FAIL clamp_hold got=%0d exp=9", count); end
    en = 0; limit = 4'd0; start = 1; step(); start = 0;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL lim0_run busy=%b done=%b exp 1/0", busy, done); end
    en = 1; step(); en = 0;
    total++; if (done !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL lim0_done done=%b count=%0d exp 1/0", done, count); end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_load();
    one_shot = 0; start = 1; step(); start = 0; en = 1;
    step(); step(); step(); step();
    total++; if (count !== 4'd4) begin bad++; $display("FAIL ld_pre got=%0d exp=4", count); end
    load = 1; load_val = 4'd7; step();
    total++; if (count !== 4'd7 || busy !== 1'b1) begin bad++; $display("FAIL ld_7 count=%0d busy=%b exp 7/1", count, busy); end
    load_val = 4'd14; step(); load = 0; en = 0;
    total++; if (count !== 4'd9) begin bad++; $display("FAIL ld_clamp got=%0d exp=9", count); end
    one_shot = 1; limit = 4'd3; start = 1; step(); start = 0;
    load = 1; load_val = 4'd7; step(); load = 0;
    total++; if (count !== 4'd7 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ld_os count=%0d busy=%b done=%b exp 7/1/0", count, busy, done); end
    en = 1; step(); en = 0;
    total++; if (count !== 4'd7 || done !== 1'b1) begin bad++; $display("FAIL ld_os_done count=%0d done=%b exp 7/1", count, done); end
    stop = 1; step(); stop = 0;
  endtask

  task automatic test_stop_restart();
    one_shot = 0; start = 1; step(); start = 0; en = 1;
    for (int i = 0; i < 6; i++) step();
    stop = 1; step(); stop = 0;
    total++; if (count !== 4'd6 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stop count=%0d busy=%b done=%b exp 6/0/0", count, busy, done); end
    step();
    total++; if (count !== 4'd6) begin bad++; $display("FAIL idle_hold got=%0d exp=6", count); end
    start = 1; load = 1; load_val = 4'd5; step(); start = 0; load = 0;
    total++; if (count !== 4'd0 || busy !== 1'b1) begin bad++; $display("FAIL start_load count=%0d busy=%b exp 0/1", count, busy); end
    step(); step(); step();
    total++; if (count !== 4'd3) begin bad++; $display("FAIL pre_reset got=%0d exp=3", count); end
    reset = 1; step(); reset = 0; en = 0;
    total++; if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset count=%0d busy=%b done=%b exp 0/0/0", count, busy, done); end
  endtask

  task automatic test_cascade();
    one_shot = 0; start = 1; step(); start = 0; en = 1;
    for (int i = 0; i < 37; i++) step();
    total++; if (count !== 4'd7 || t_count !== 4'd3) begin bad++; $display("FAIL casc_37 units=%0d tens=%0d exp 7/3", count, t_count); end
    for (int i = 0; i < 63; i++) step();
    en = 0;
    total++; if (count !== 4'd0 || t_count !== 4'd0) begin bad++; $display("FAIL casc_100 units=%0d tens=%0d exp 0/0", count, t_count); end
    total++; if (t_overflow !== 1'b1 || t_busy !== 1'b1) begin bad++; $display("FAIL casc_tens_ovf ovf=%b busy=%b exp 1/1", t_overflow, t_busy); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_free_run();
    test_one_shot();
    test_limit_clamp();
    test_load();
    test_stop_restart();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
